// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single synchronous 32-bit memory port: round-robin
// fairness, bounded bus lock for atomic sequences, one-cycle read return.
module mem_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_valid_o,
  output logic        m1_valid_o,
  output logic [31:0] m0_data_o,
  output logic [31:0] m1_data_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic        last_q;
  logic        locked_q;
  logic [7:0]  hold_q;
  logic [1:0]  rd_pend_q;
  logic [31:0] m0_data_q;
  logic [31:0] m1_data_q;

  logic        owner_req;
  logic        other_req;
  logic        gnt0;
  logic        gnt1;
  logic        brk;

  // Owner is the last granted master; "other" is the one waiting on it.
  assign owner_req = last_q ? m1_req_i : m0_req_i;
  assign other_req = last_q ? m0_req_i : m1_req_i;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    brk  = 1'b0;
    if (!reset_i) begin
      if (locked_q) begin
        if (other_req && (hold_q == HOLD_LIM)) begin
          brk = 1'b1;
          if (last_q) gnt0 = 1'b1;
          else        gnt1 = 1'b1;
        end else if (owner_req) begin
          if (last_q) gnt1 = 1'b1;
          else        gnt0 = 1'b1;
        end
      end else if (m0_req_i && m1_req_i) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  always_comb begin
    mem_addr_o = 32'd0;
    mem_we_o   = 1'b0;
    mem_data_o = 32'd0;
    if (gnt0) begin
      mem_addr_o = m0_addr_i;
      mem_we_o   = m0_we_i;
      mem_data_o = m0_data_i;
    end else if (gnt1) begin
      mem_addr_o = m1_addr_i;
      mem_we_o   = m1_we_i;
      mem_data_o = m1_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      last_q    <= 1'b1;
      locked_q  <= 1'b0;
      hold_q    <= 8'd0;
      rd_pend_q <= 2'b00;
      m0_data_q <= 32'd0;
      m1_data_q <= 32'd0;
    end else begin
      rd_pend_q <= {gnt1 & ~m1_we_i, gnt0 & ~m0_we_i};
      if (rd_pend_q[0]) m0_data_q <= mem_data_i;
      if (rd_pend_q[1]) m1_data_q <= mem_data_i;
      if (!locked_q || brk) begin
        hold_q <= 8'd0;
      end else if (other_req) begin
        hold_q <= hold_q + 8'd1;
      end
      if (gnt0 || gnt1) begin
        last_q   <= gnt1;
        locked_q <= gnt1 ? m1_lock_i : m0_lock_i;
      end
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Read data passes straight through on the return cycle, then is held.
  assign m0_valid_o = rd_pend_q[0] & ~reset_i;
  assign m1_valid_o = rd_pend_q[1] & ~reset_i;
  assign m0_data_o  = reset_i ? 32'd0 : (rd_pend_q[0] ? mem_data_i : m0_data_q);
  assign m1_data_o  = reset_i ? 32'd0 : (rd_pend_q[1] ? mem_data_i : m1_data_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous memory model, rule-level arbitration
// model compared every cycle, plus directed literal expectations.
module tb_mem_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        m0_req_i, m0_we_i, m0_lock_i;
  logic [31:0] m0_addr_i, m0_data_i;
  logic        m1_req_i, m1_we_i, m1_lock_i;
  logic [31:0] m1_addr_i, m1_data_i;
  logic        m0_gnt_o, m1_gnt_o, m0_valid_o, m1_valid_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_we_o;
  logic [31:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_i(reset_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_valid_o(m0_valid_o), .m1_valid_o(m1_valid_o),
    .m0_data_o(m0_data_o), .m1_data_o(m1_data_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: read data appears the cycle after the address.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);

  always @(posedge clk) begin
    if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_data_o;
    mem_data_i <= mem[mem_addr_o[9:2]];
  end

  // Rule-level model: who owns the bus, lock and its hold count, pending returns.
  int          md_last = 1;
  bit          md_locked = 0;
  int          md_hold = 0;
  bit          md_ok = 0;
  bit          md_pend [2];
  logic [31:0] md_pdata [2];
  logic [31:0] md_held [2];
  int          e_win;
  bit          e_brk;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    logic [1:0]  rq;
    logic [31:0] ea, ed;
    logic        ew;
    rq = {m1_req_i, m0_req_i};
    e_win = -1;
    e_brk = 0;
    if (!reset_i) begin
      if (md_locked) begin
        if (rq[1 - md_last] && md_hold == MAX_HOLD) begin
          e_win = 1 - md_last;
          e_brk = 1;
        end else if (rq[md_last]) e_win = md_last;
      end else if (rq == 2'b11) e_win = 1 - md_last;
      else if (rq[0]) e_win = 0;
      else if (rq[1]) e_win = 1;
    end
    ea = (e_win == 0) ? m0_addr_i : (e_win == 1) ? m1_addr_i : 32'd0;
    ed = (e_win == 0) ? m0_data_i : (e_win == 1) ? m1_data_i : 32'd0;
    ew = (e_win == 0) ? m0_we_i : (e_win == 1) ? m1_we_i : 1'b0;
    e_rd = mem[ea[9:2]];
    if (md_ok) begin
      chk("gnt", {30'd0, m1_gnt_o, m0_gnt_o}, {30'd0, e_win == 1, e_win == 0});
      chk("mem_addr", mem_addr_o, ea);
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, ew});
      chk("mem_data", mem_data_o, ed);
      chk("valid", {30'd0, m1_valid_o, m0_valid_o},
          reset_i ? 32'd0 : {30'd0, md_pend[1], md_pend[0]});
      chk("m0_data", m0_data_o, reset_i ? 32'd0 : (md_pend[0] ? md_pdata[0] : md_held[0]));
      chk("m1_data", m1_data_o, reset_i ? 32'd0 : (md_pend[1] ? md_pdata[1] : md_held[1]));
    end
  end

  always @(posedge clk) begin
    if (reset_i) begin
      md_last = 1; md_locked = 0; md_hold = 0; md_ok = 1;
      for (int n = 0; n < 2; n++) begin
        md_pend[n] = 0; md_pdata[n] = 32'd0; md_held[n] = 32'd0;
      end
    end else if (md_ok) begin
      for (int n = 0; n < 2; n++) if (md_pend[n]) md_held[n] = md_pdata[n];
      md_pend[0] = (e_win == 0) && !m0_we_i;
      md_pend[1] = (e_win == 1) && !m1_we_i;
      md_pdata[0] = e_rd;
      md_pdata[1] = e_rd;
      if (!md_locked || e_brk) md_hold = 0;
      else if ((md_last == 0) ? m1_req_i : m0_req_i) md_hold++;
      if (e_win >= 0) begin
        md_last = e_win;
        md_locked = (e_win == 0) ? m0_lock_i : m1_lock_i;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m0_lock_i = 0; m0_addr_i = 0; m0_data_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_lock_i = 0; m1_addr_i = 0; m1_data_i = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1;
    step();
    reset_i = 0;
  endtask

  task automatic lit_gnt(input string name, input logic [1:0] exp);
    #1;
    chk(name, {30'd0, m1_gnt_o, m0_gnt_o}, {30'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    idle();
    reset_i = 1;
    step();
    step();
    reset_i = 0;

    // Round-robin reads, m0 first after reset.
    m0_req_i = 1; m0_addr_i = 32'h100;
    m1_req_i = 1; m1_addr_i = 32'h200;
    for (int i = 0; i < 6; i++) begin
      lit_gnt("rr_gnt", (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 1) begin
        chk("rr_m0_valid", {31'd0, m0_valid_o}, 32'd1);
        chk("rr_m0_data", m0_data_o, 32'h1000_0040);
      end
      if (i == 2) begin
        chk("rr_m1_valid", {31'd0, m1_valid_o}, 32'd1);
        chk("rr_m1_data", m1_data_o, 32'h1000_0080);
      end
      step();
    end
    idle();
    step();

    // m0 alone: three back-to-back writes, then read one back.
    for (int k = 0; k < 3; k++) begin
      m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'(k * 4); m0_data_i = 32'hDEAD_0000 + 32'(k);
      lit_gnt("wr_gnt", 2'b01);
      chk("wr_we", {31'd0, mem_we_o}, 32'd1);
      chk("wr_addr", mem_addr_o, 32'(k * 4));
      step();
    end
    idle();
    #1;
    chk("wr_no_valid", {31'd0, m0_valid_o}, 32'd0);
    step();
    m0_req_i = 1; m0_addr_i = 32'h4;
    step();
    idle();
    #1;
    chk("rb_valid", {31'd0, m0_valid_o}, 32'd1);
    chk("rb_data", m0_data_o, 32'hDEAD_0001);
    step();

    // m0 holds a lock against a continuously requesting m1.
    do_reset();
    m0_req_i = 1; m0_lock_i = 1; m0_addr_i = 32'h100;
    m1_req_i = 1; m1_addr_i = 32'h200;
    for (int i = 0; i < 7; i++) begin
      lit_gnt("lock_gnt", (i == 5) ? 2'b10 : 2'b01);
      step();
    end

    // m1 locks then goes idle: m0 waits MAX_HOLD cycles.
    do_reset();
    m1_req_i = 1; m1_lock_i = 1; m1_addr_i = 32'h200;
    lit_gnt("idle_lock_m1", 2'b10);
    step();
    m1_req_i = 0; m1_lock_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h100;
    for (int i = 0; i <= MAX_HOLD; i++) begin
      lit_gnt("idle_lock_wait", (i == MAX_HOLD) ? 2'b01 : 2'b00);
      step();
    end

    // m1 locks then releases explicitly.
    do_reset();
    m1_req_i = 1; m1_lock_i = 1; m1_addr_i = 32'h200;
    lit_gnt("rel_lock", 2'b10);
    step();
    m1_lock_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h100;
    lit_gnt("rel_owner", 2'b10);
    step();
    m1_req_i = 0;
    lit_gnt("rel_m0", 2'b01);
    step();

    // Reset right after an m1 read grant drops the return.
    do_reset();
    m1_req_i = 1; m1_addr_i = 32'h200;
    lit_gnt("rst_m1_gnt", 2'b10);
    step();
    reset_i = 1; m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h100;
    lit_gnt("rst_gnt_off", 2'b00);
    chk("rst_m1_valid", {31'd0, m1_valid_o}, 32'd0);
    chk("rst_m1_data", m1_data_o, 32'd0);
    step();
    reset_i = 0; m1_req_i = 1;
    lit_gnt("rst_tie_m0", 2'b01);
    chk("rst_after_valid", {31'd0, m1_valid_o}, 32'd0);
    step();
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
